// File: rtl/membus_ram_responder_if.sv
// ---------------------------------------------------------------------------
// membus_ram_responder_if
//   Request/response bundle between a single membus master and the RAM
//   responder.
//   Ports (through modports):
//     valid  master->slave  request valid
//     ready  slave->master  request accept
//     addr   master->slave  byte offset into the RAM (XLEN bits)
//     wen    master->slave  1 = write, 0 = read
//     wdata  master->slave  write data (DATA_WIDTH bits)
//     wmask  master->slave  byte enables (DATA_WIDTH/8 bits)
//     rvalid slave->master  one-cycle response strobe
//     rdata  slave->master  read data, 0 for writes
// ---------------------------------------------------------------------------
interface membus_ram_responder_if #(
    parameter int XLEN       = 64,
    parameter int DATA_WIDTH = 64
);
    logic                    valid;
    logic                    ready;
    logic [XLEN-1:0]         addr;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wmask;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output valid, addr, wen, wdata, wmask,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wdata, wmask,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/membus_ram_responder.sv
// ---------------------------------------------------------------------------
// membus_ram_responder
//   Membus slave owning a word-addressed on-chip RAM of DEPTH 64-bit words.
//   One request outstanding at a time; every accepted request (read or
//   write) yields exactly one rvalid pulse LATENCY cycles after its accept.
//   Ports:
//     clk   in   clock, rising edge
//     rst   in   asynchronous, active-low reset
//     bus   slave modport of membus_ram_responder_if (valid/ready/addr/wen/
//           wdata/wmask/rvalid/rdata)
//     oob   out  pulses with rvalid when the request address was >= DEPTH*8
//   Optional feature: define MEMBUS_RAM_STALL_EN to gate ready with bit 0 of
//   a free-running 16-bit LFSR (random backpressure for system testing).
// ---------------------------------------------------------------------------
module membus_ram_responder #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    membus_ram_responder_if.slave       bus,
    output logic                        oob
);
    localparam int DATA_WIDTH = 64;
    localparam int NB         = DATA_WIDTH / 8;
    localparam int AW         = $clog2(DEPTH);
    localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg;
    logic                    ready_reg;
    logic                    rvalid_reg;
    logic                    oob_reg;
    logic                    wen_reg;
    logic                    oob_lat_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [DATA_WIDTH-1:0]   ram_q;

    logic                    accept;
    logic                    ram_en;
    logic                    in_range;
    logic [AW-1:0]           idx;

    assign accept   = bus.valid && bus.ready;
    // RAM is never touched while reset is held, so a write is either fully
    // committed at a clean accept edge or not at all.
    assign ram_en   = accept && rst;
    assign in_range = bus.addr < XLEN'(DEPTH * 8);
    assign idx      = bus.addr[3 +: AW];

`ifdef MEMBUS_RAM_STALL_EN
    logic [15:0] lfsr_reg;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5],
                         lfsr_reg[15:1]};
        end
    end

    assign bus.ready = ready_reg & lfsr_reg[0];
`else
    assign bus.ready = ready_reg;
`endif

    // One byte-wide RAM per lane so byte enables map onto independent
    // arrays; read data is registered at the accept edge.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (ram_en) begin
                    if (bus.wen) begin
                        if (in_range && bus.wmask[gi]) begin
                            mem[idx] <= bus.wdata[gi*8 +: 8];
                        end
                    end else begin
                        q_reg <= mem[idx];
                    end
                end
            end

            assign ram_q[gi*8 +: 8] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            ready_reg   <= 1'b1;
            rvalid_reg  <= 1'b0;
            oob_reg     <= 1'b0;
            wen_reg     <= 1'b0;
            oob_lat_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            rvalid_reg <= 1'b0;
            oob_reg    <= 1'b0;
            case (state_reg)
                IDLE, RESP: begin
                    if (accept) begin
                        wen_reg     <= bus.wen;
                        oob_lat_reg <= !in_range;
                        if (LATENCY == 1) begin
                            state_reg  <= RESP;
                            ready_reg  <= 1'b1;
                            rvalid_reg <= 1'b1;
                            oob_reg    <= !in_range;
                        end else begin
                            state_reg <= WAIT;
                            ready_reg <= 1'b0;
                            cnt_reg   <= CNT_W'(LATENCY - 1);
                        end
                    end else begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg  <= RESP;
                        ready_reg  <= 1'b1;
                        rvalid_reg <= 1'b1;
                        oob_reg    <= oob_lat_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rvalid = rvalid_reg;
    // Write and out-of-range responses carry zero data.
    assign bus.rdata  = (rvalid_reg && !wen_reg && !oob_lat_reg) ? ram_q : '0;
    assign oob        = oob_reg;

endmodule
